// File: rtl/demux_1_4_stream.sv
// Registered 1:4 stream demux with a one-entry holding register per channel.
// Define DEMUX_1_4_CNT_EN to add per-channel 16-bit drain counters on xfer_cnt.
module demux_1_4_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic [1:0]       s_sel,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [WIDTH-1:0] y_0,
  output logic [WIDTH-1:0] y_1,
  output logic [WIDTH-1:0] y_2,
  output logic [WIDTH-1:0] y_3,
  output logic [3:0]       y_valid,
  input  logic [3:0]       y_ready
`ifdef DEMUX_1_4_CNT_EN
  ,
  output logic [63:0]      xfer_cnt
`endif
);

  logic [WIDTH-1:0] y_q [4];
  logic [3:0]       ld;
  logic [3:0]       drain;
  logic             acc;

  // Target channel can take a word if empty or emptying this cycle
  always_comb begin
    i_ready = ~y_valid[s_sel] | y_ready[s_sel];
  end

  assign acc   = i_valid & i_ready;
  assign drain = y_valid & y_ready;

  // One-hot load strobe for the selected channel
  always_comb begin
    ld = 4'b0000;
    unique case (1'b1)
      (s_sel == 2'd0): ld = {3'b000, acc};
      (s_sel == 2'd1): ld = {2'b00, acc, 1'b0};
      (s_sel == 2'd2): ld = {1'b0, acc, 2'b00};
      (s_sel == 2'd3): ld = {acc, 3'b000};
      default:         ld = 4'b0000;
    endcase
  end

  // Occupancy: load wins over drain, so drain+load keeps the channel full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_valid <= 4'b0000;
    end else begin
      y_valid <= (y_valid & ~drain) | ld;
    end
  end

  // Holding registers keep their last word after a drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) y_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (ld[k]) y_q[k] <= i_data;
      end
    end
  end

  assign y_0 = y_q[0];
  assign y_1 = y_q[1];
  assign y_2 = y_q[2];
  assign y_3 = y_q[3];

`ifdef DEMUX_1_4_CNT_EN
  logic [15:0] cnt_q [4];

  // Per-channel drain counters, wrapping at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) cnt_q[k] <= 16'h0000;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (drain[k]) cnt_q[k] <= cnt_q[k] + 16'h0001;
      end
    end
  end

  assign xfer_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule
